// File: rtl/riscv_v_pkg.sv
// Shared types and constants for the RISC-V vector configuration (vsetvl*) logic.
package riscv_v_pkg;

  localparam int RISCV_V_XLEN = 32;

  typedef enum logic [1:0] {
    VSET_VSETVLI  = 2'd0,
    VSET_VSETIVLI = 2'd1,
    VSET_VSETVL   = 2'd2
  } riscv_v_vset_op_e;

  typedef struct packed {
    logic                    vill;
    logic [RISCV_V_XLEN-10:0] rsvd;
    logic                    vma;
    logic                    vta;
    logic [2:0]              vsew;
    logic [2:0]              vlmul;
  } riscv_v_vtype_t;

  typedef logic [RISCV_V_XLEN-1:0] riscv_v_vl_t;

  localparam int VTYPE_VLMUL_OFF = 0;
  localparam int VTYPE_VSEW_OFF  = 3;
  localparam int VTYPE_VTA_BIT   = 6;
  localparam int VTYPE_VMA_BIT   = 7;

  localparam logic [2:0] LMUL_1    = 3'b000;
  localparam logic [2:0] LMUL_2    = 3'b001;
  localparam logic [2:0] LMUL_4    = 3'b010;
  localparam logic [2:0] LMUL_8    = 3'b011;
  localparam logic [2:0] LMUL_RSVD = 3'b100;
  localparam logic [2:0] LMUL_F8   = 3'b101;
  localparam logic [2:0] LMUL_F4   = 3'b110;
  localparam logic [2:0] LMUL_F2   = 3'b111;

  // Everything above vma is reserved, including the vill position of an rs2 source.
  localparam logic [63:0] VTYPE_RSVD_MASK = 64'hFFFF_FFFF_FFFF_FF00;

endpackage

// File: rtl/riscv_v_vtype_decode.sv
// Combinational vtype legality check and VLMAX computation.
module riscv_v_vtype_decode
  import riscv_v_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic [XLEN-1:0] vtype_raw,
  output logic            vill,
  output logic [XLEN-1:0] vlmax
);

  localparam int ELEN_LOG2 = $clog2(ELEN);
  localparam logic [XLEN-1:0] VLEN_W = XLEN'(VLEN);

  logic [2:0] vlmul;
  logic [2:0] vsew;
  logic [2:0] frac_k;
  logic [3:0] sew_log2;
  logic       frac;
  logic       rsvd_set;
  logic       sew_bad;
  logic       frac_bad;

  assign vlmul    = vtype_raw[VTYPE_VLMUL_OFF +: 3];
  assign vsew     = vtype_raw[VTYPE_VSEW_OFF +: 3];
  assign rsvd_set = |(vtype_raw & VTYPE_RSVD_MASK[XLEN-1:0]);
  assign frac     = vlmul[2];
  // 111/110/101 encode 1/2, 1/4, 1/8, so the negated encoding is the shift k
  assign frac_k   = 3'd0 - vlmul;
  assign sew_log2 = {1'b0, vsew} + 4'd3;

  assign sew_bad  = int'(sew_log2) > ELEN_LOG2;
  assign frac_bad = frac && ((int'(sew_log2) + int'(frac_k)) > ELEN_LOG2);
  assign vill     = (vlmul == LMUL_RSVD) || sew_bad || frac_bad || rsvd_set;

  always_comb begin
    vlmax = '0;
    if (frac) begin
      vlmax = VLEN_W >> (sew_log2 + {1'b0, frac_k});
    end else begin
      vlmax = (VLEN_W << vlmul[1:0]) >> sew_log2;
    end
  end

endmodule

// File: rtl/riscv_v_vsetvl.sv
// vsetvli / vsetivli / vsetvl execution: decode vtype, compute vl, write CSRs and return rd.
module riscv_v_vsetvl
  import riscv_v_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  riscv_v_vset_op_e req_op,
  input  logic             rs1_is_x0,
  input  logic             rd_is_x0,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [10:0]      zimm,
  input  logic [4:0]       uimm,
  input  riscv_v_vl_t      vl_cur,
  output riscv_v_vtype_t   vtype_data_out,
  output logic             vtype_wr_en,
  output riscv_v_vl_t      vl_data_out,
  output logic             vl_wr_en,
  output logic             vstart_wr_en,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_COMMIT,
    ST_RESP
  } state_e;

  state_e           state_q, state_d;
  riscv_v_vset_op_e op_q, op_d;
  logic             rs1_x0_q, rs1_x0_d;
  logic             rd_x0_q, rd_x0_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
  logic [10:0]      zimm_q, zimm_d;
  logic [4:0]       uimm_q, uimm_d;
  logic             req_ready_q, req_ready_d;
  logic             wr_en_q, wr_en_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]  rd_data_q, rd_data_d;
  riscv_v_vtype_t   vtype_q, vtype_d;
  riscv_v_vl_t      vl_q, vl_d;

  logic [XLEN-1:0]  vtype_src;
  logic [XLEN-1:0]  avl;
  logic [XLEN-1:0]  vlmax;
  logic [XLEN-1:0]  vl_new;
  logic             vill;
  riscv_v_vtype_t   vtype_new;

  assign vtype_src = (op_q == VSET_VSETVL) ? rs2_data_q : {{(XLEN-11){1'b0}}, zimm_q};

  riscv_v_vtype_decode #(
    .XLEN (XLEN),
    .VLEN (VLEN),
    .ELEN (ELEN)
  ) u_decode (
    .vtype_raw (vtype_src),
    .vill      (vill),
    .vlmax     (vlmax)
  );

  always_comb begin
    avl = XLEN'(vl_cur);
    if (op_q == VSET_VSETIVLI) begin
      avl = {{(XLEN-5){1'b0}}, uimm_q};
    end else if (!rs1_x0_q) begin
      avl = rs1_data_q;
    end else if (!rd_x0_q) begin
      avl = '1;
    end
  end

  always_comb begin
    vl_new    = vill ? '0 : ((avl < vlmax) ? avl : vlmax);
    vtype_new = '0;
    if (vill) begin
      vtype_new.vill = 1'b1;
    end else begin
      vtype_new.vlmul = vtype_src[VTYPE_VLMUL_OFF +: 3];
      vtype_new.vsew  = vtype_src[VTYPE_VSEW_OFF +: 3];
      vtype_new.vta   = vtype_src[VTYPE_VTA_BIT];
      vtype_new.vma   = vtype_src[VTYPE_VMA_BIT];
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rs1_x0_d    = rs1_x0_q;
    rd_x0_d     = rd_x0_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    zimm_d      = zimm_q;
    uimm_d      = uimm_q;
    req_ready_d = req_ready_q;
    wr_en_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rd_data_d   = rd_data_q;
    vtype_d     = vtype_q;
    vl_d        = vl_q;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          op_d        = req_op;
          rs1_x0_d    = rs1_is_x0;
          rd_x0_d     = rd_is_x0;
          rs1_data_d  = rs1_data;
          rs2_data_d  = rs2_data;
          zimm_d      = zimm;
          uimm_d      = uimm;
          req_ready_d = 1'b0;
          state_d     = ST_CALC;
        end
      end
      ST_CALC: begin
        vtype_d     = vtype_new;
        vl_d        = riscv_v_vl_t'(vl_new);
        rd_data_d   = vl_new;
        wr_en_d     = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = ST_COMMIT;
      end
      ST_COMMIT, ST_RESP: begin
        state_d = ST_RESP;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= VSET_VSETVLI;
      rs1_x0_q    <= 1'b0;
      rd_x0_q     <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      zimm_q      <= '0;
      uimm_q      <= '0;
      req_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rd_data_q   <= '0;
      vtype_q     <= '0;
      vl_q        <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rs1_x0_q    <= rs1_x0_d;
      rd_x0_q     <= rd_x0_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      zimm_q      <= zimm_d;
      uimm_q      <= uimm_d;
      req_ready_q <= req_ready_d;
      wr_en_q     <= wr_en_d;
      rsp_valid_q <= rsp_valid_d;
      rd_data_q   <= rd_data_d;
      vtype_q     <= vtype_d;
      vl_q        <= vl_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign vtype_wr_en    = wr_en_q;
  assign vl_wr_en       = wr_en_q;
  assign vstart_wr_en   = wr_en_q;
  assign vtype_data_out = vtype_q;
  assign vl_data_out    = vl_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rd_data    = rd_data_q;

endmodule

// File: doc/riscv_v_vsetvl.md
RISCV_V_VSETVL -- requirements
Module: riscv_v_vsetvl

Interface
REQ-001 Parameter XLEN, 32, scalar register width.
REQ-002 Parameter VLEN, 128, vector register length in bits.
REQ-003 Parameter ELEN, 32, maximum element width in bits (legal values 32 or 64).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_valid  in  1  request offered.
REQ-008 req_ready  out  1  block can accept a request.
REQ-009 req_op  in  riscv_v_vset_op_e  selects VSETVLI, VSETIVLI or VSETVL.
REQ-010 rs1_is_x0 / rd_is_x0  in  1 each  rs1 or rd index is zero.
REQ-011 rs1_data / rs2_data  in  XLEN each  scalar operands.
REQ-012 zimm  in  11  immediate vtype for VSETVLI/VSETIVLI.
REQ-013 uimm  in  5  immediate AVL for VSETIVLI.
REQ-014 vl_cur  in  riscv_v_vl_t  current vl from the CSR block.
REQ-015 vtype_data_out / vtype_wr_en  out  riscv_v_vtype_t / 1  vtype write port.
REQ-016 vl_data_out / vl_wr_en  out  riscv_v_vl_t / 1  vl write port.
REQ-017 vstart_wr_en  out  1  vstart clear; written data is always 0.
REQ-018 rsp_valid / rsp_ready / rsp_rd_data  out / in / out  1 / 1 / XLEN  rd writeback handshake.

Function
REQ-019 The FSM SHALL have states IDLE, CALC, COMMIT and RESP.
- IDLE: req_ready=1. req_valid&&req_ready captures all request inputs and moves to CALC.
- CALC: decodes the vtype, computes vl and samples vl_cur, then moves to COMMIT.
- COMMIT: rsp_valid=1; goes to IDLE if rsp_ready, else to RESP.
- RESP: holds rsp_valid and rsp_rd_data until rsp_ready, then goes to IDLE.
REQ-020 req_ready SHALL be 0 in every state except IDLE.
REQ-021 vtype_wr_en, vl_wr_en and vstart_wr_en SHALL pulse together for exactly one cycle, in COMMIT only; none of them SHALL be re-asserted in RESP.
REQ-022 Latency SHALL be fixed: a request accepted at edge N gives write enables and rsp_valid in cycle N+2.
REQ-023 The vtype source SHALL be zimm for VSETVLI/VSETIVLI and rs2_data for VSETVL.
REQ-024 The vtype fields are: vlmul[2:0], vsew[5:3], vta[6], vma[7]; all bits above bit 7 are reserved.
REQ-025 SEW SHALL be 8<<vsew.
REQ-026 LMUL encodings SHALL be: 000=1, 001=2, 010=4, 011=8, 111=1/2, 110=1/4, 101=1/8.
REQ-027 VLMAX SHALL be (VLEN/SEW)<<vlmul for integer LMUL and (VLEN/SEW)>>k for fractional LMUL 1/2^k.
REQ-028 vill SHALL be set when any of these hold:
- vlmul=100;
- SEW>ELEN;
- SEW>LMUL*ELEN for fractional LMUL;
- any reserved vtype bit is nonzero.
REQ-029 When vill is set, the written vtype SHALL have only vill=1 (all other fields 0), and vl SHALL be 0.
REQ-030 AVL selection:
- VSETIVLI: zero-extended uimm.
- Otherwise, rs1 not x0: rs1_data.
- rs1 x0, rd not x0: all-ones (vl=VLMAX).
- rs1 x0, rd x0: vl_cur.
REQ-031 vl SHALL be min(AVL, VLMAX), compared at full XLEN width with no truncation before the compare.
REQ-032 rsp_rd_data SHALL be the new vl zero-extended to XLEN; rsp_valid SHALL be asserted even when rd is x0.

Reset
REQ-033 On rst the FSM SHALL go to IDLE asynchronously, and all write enables, rsp_valid, rsp_rd_data, vtype_data_out and vl_data_out SHALL be 0.
REQ-034 req_ready SHALL be 0 while rst is high and 1 from the first cycle after release.
REQ-035 A reset asserted in CALC, COMMIT or RESP SHALL abort the operation, with no CSR write after deassertion.

Structure
REQ-036 riscv_v_vset_op_e, the vtype field offsets, the LMUL encodings and a reserved-bit mask constant SHALL live in riscv_v_pkg; riscv_v_vtype_t and riscv_v_vl_t are reused unchanged.
REQ-037 The vtype legality check and VLMAX computation SHALL be a combinational sub-module riscv_v_vtype_decode, instantiated once.

Verification (VLEN=128, ELEN=32)
REQ-038 VSETVLI, rs1_data=100, zimm=0x010 (SEW32, LMUL1) -> vl=4, rd=4, vtype.vsew=2, write enables at N+2.
REQ-039 VSETIVLI, uimm=3, zimm=0x000 -> vl=3, rd=3.
REQ-040 VSETVLI, zimm=0x018 (SEW64) -> vill=1, vl=0, rd=0.
REQ-041 VSETVLI, rs1=x0, rd not x0, zimm=0x009 (SEW16, LMUL2) -> vl=16; repeating with rd=x0 and vl_cur=5 -> vl=5.
REQ-042 rsp_ready held low for 3 cycles -> rsp_valid and rsp_rd_data stable, exactly one write pulse, req_ready=0 until the handshake completes.
REQ-043 rst pulsed while in CALC -> no write enable ever fires, and req_ready=1 one cycle after release.
